fifo_rd_stream: RTL

//  Read-side drain engine for the async FIFO, in the read clock domain.

---
 rtl/fifo_rd_stream.sv | 76 +++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the read port of an async FIFO into a bubble-free valid/ready
// stream through a 2-entry buffer. Define FIFO_RD_STATS_EN to enable the word_cnt counter.
module fifo_rd_stream #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrstn,
    input  logic             fifo_empty,
    output logic             fifo_rden,
    input  logic [DW-1:0]    fifo_rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       buf_level,
    output logic [CNT_W-1:0] word_cnt
);

    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic [1:0]    count;
    logic          inflight;
    logic          pop;
    logic [2:0]    occupancy;
    logic [1:0]    slot;

    assign pop       = out_valid & out_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rden = rrstn & ~fifo_empty & (occupancy < 3'd2);
    assign slot      = count - {1'b0, pop};
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign buf_level = count;

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rden;
            count    <= count - {1'b0, pop} + {1'b0, inflight};
        end
    end

    // Shift on pop first; a landing word then overwrites the slot just past the survivors.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (pop) begin
                head <= tail;
            end
            if (inflight) begin
                if (slot == 2'd0) begin
                    head <= fifo_rd_data;
                end else begin
                    tail <= fifo_rd_data;
                end
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            word_cnt <= '0;
        end else if (pop && (word_cnt != '1)) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end
`else
    assign word_cnt = '0;
`endif

endmodule
